// File: rtl/script_loader_pkg.sv
// Shared definitions for the script loader and the automatic executor:
// FSM encoding, read-path selection and the executor opcode set.
package script_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_LO,
    LOAD_HI,
    DONE,
    ERR
  } state_t;

  typedef enum logic [1:0] {
    SEL_NOP,
    SEL_END,
    SEL_DATA
  } read_sel_t;

  // Executor opcodes; none of them is zero, so an all-zero word stalls the executor
  localparam logic [4:0] OP_UP    = 5'b00001;
  localparam logic [4:0] OP_DOWN  = 5'b00010;
  localparam logic [4:0] OP_LEFT  = 5'b00011;
  localparam logic [4:0] OP_RIGHT = 5'b00100;
  localparam logic [4:0] OP_WAIT  = 5'b00101;
  localparam logic [4:0] OP_END   = 5'b10100;

  localparam logic [15:0] NOP_WORD = 16'h0000;
  localparam logic [15:0] END_WORD = {8'h00, 3'b000, OP_END};

  function automatic logic [15:0] end_word(input logic [4:0] op);
    return {8'h00, 3'b000, op};
  endfunction

endpackage

// File: rtl/script_loader_if.sv
// Host/executor-facing bus of the script loader: UART byte stream in,
// instruction fetch by byte pc, and load status out.
interface script_loader_if #(
  parameter int ADDR_W = 8
);
  logic              load_start;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       script;
  logic              ready;
  logic [ADDR_W-1:0] len;
  logic              error;

  modport master (
    output load_start, rx_valid, rx_byte, pc,
    input  script, ready, len, error
  );

  modport slave (
    input  load_start, rx_valid, rx_byte, pc,
    output script, ready, len, error
  );
endinterface

// File: rtl/script_loader_ram.sv
// Byte-wide script store: one byte write port and a registered read port
// returning the 16-bit word {odd byte, even byte}. The array has no reset.
module script_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-2:0] raddr,
  output logic [15:0]       rdata
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= {mem[{raddr, 1'b1}], mem[{raddr, 1'b0}]};
  end
endmodule

// File: rtl/script_loader.sv
// Script store for the automatic executor: packs UART bytes into 16-bit
// instructions, detects END / overflow / timeout, and serves words by pc.
module script_loader
  import script_loader_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter logic [4:0]  END_OP      = OP_END,
  parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000
) (
  input logic            clk,
  input logic            rst,
  script_loader_if.slave bus
);
  localparam logic [ADDR_W-1:0] PTR_ONE    = 1;
  localparam logic [ADDR_W:0]   LEN_ONE    = 1;
  localparam logic [23:0]       TIMER_LAST = TIMEOUT_CYC - 24'd1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wptr, wptr_nxt;
  logic [ADDR_W:0]   len_q, len_nxt;
  logic [23:0]       timer, timer_nxt;
  logic [4:0]        lo_op, lo_op_nxt;
  read_sel_t         sel_q, sel_nxt;
  logic              we;
  logic [15:0]       rd_word;
  logic [ADDR_W:0]   word_base;
  logic              unused_pc_lsb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wptr  <= '0;
      len_q <= '0;
      timer <= '0;
      lo_op <= '0;
      sel_q <= SEL_NOP;
    end else begin
      state <= state_nxt;
      wptr  <= wptr_nxt;
      len_q <= len_nxt;
      timer <= timer_nxt;
      lo_op <= lo_op_nxt;
      sel_q <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wptr_nxt  = wptr;
    len_nxt   = len_q;
    timer_nxt = timer;
    lo_op_nxt = lo_op;
    we        = 1'b0;
    if (bus.load_start) begin
      state_nxt = LOAD_LO;
      wptr_nxt  = '0;
      len_nxt   = '0;
      timer_nxt = '0;
    end else begin
      case (state)
        LOAD_LO: begin
          if (bus.rx_valid) begin
            we        = 1'b1;
            lo_op_nxt = bus.rx_byte[4:0];
            wptr_nxt  = wptr + PTR_ONE;
            timer_nxt = '0;
            state_nxt = LOAD_HI;
          end
        end
        LOAD_HI: begin
          if (bus.rx_valid) begin
            we       = 1'b1;
            wptr_nxt = wptr + PTR_ONE;
            len_nxt  = {1'b0, wptr} + LEN_ONE;
            // The carry bit of the widened count flags a completely filled store
            if (lo_op == END_OP) begin
              state_nxt = DONE;
            end else if (len_nxt[ADDR_W]) begin
              state_nxt = ERR;
            end else begin
              state_nxt = LOAD_LO;
            end
          end else if (timer == TIMER_LAST) begin
            state_nxt = ERR;
          end else begin
            timer_nxt = timer + 24'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // len_q carries one extra bit so a script that exactly fills the store still
  // resolves reads correctly; the port shows only the low ADDR_W bits.
  assign word_base = {1'b0, bus.pc[ADDR_W-1:1], 1'b0};

  always_comb begin
    sel_nxt = SEL_NOP;
    if (state == DONE) begin
      sel_nxt = (word_base >= len_q) ? SEL_END : SEL_DATA;
    end
  end

  script_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wptr),
    .wdata (bus.rx_byte),
    .raddr (bus.pc[ADDR_W-1:1]),
    .rdata (rd_word)
  );

  always_comb begin
    case (sel_q)
      SEL_DATA: bus.script = rd_word;
      SEL_END:  bus.script = end_word(END_OP);
      default:  bus.script = NOP_WORD;
    endcase
  end

  assign bus.ready     = (state == DONE);
  assign bus.error     = (state == ERR);
  assign bus.len       = len_q[ADDR_W-1:0];
  assign unused_pc_lsb = bus.pc[0];
endmodule

// File: tb/tb_script_loader.sv
// Bench for script_loader: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a byte-counting model.
module tb_script_loader;
  localparam int          AW    = 3;
  localparam int          DEPTH = 8;
  localparam logic [23:0] TO    = 24'd16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  script_loader_if #(.ADDR_W(AW)) bus ();

  script_loader #(
    .ADDR_W      (AW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  // Model: bytes of the current load, how many arrived, idle clocks mid-word
  logic [7:0]  m_mem [DEPTH];
  int          m_count, m_len, m_idle;
  bit          m_loading, m_done, m_err;
  logic [15:0] m_script;

  always @(posedge clk) begin
    if (rst) begin
      m_loading = 0; m_done = 0; m_err = 0;
      m_count = 0; m_len = 0; m_idle = 0;
      m_script = 16'h0000;
    end else begin
      int base;
      base = int'(bus.pc) & ~1;
      if (!m_done)           m_script = 16'h0000;
      else if (base >= m_len) m_script = 16'h0014;
      else                    m_script = {m_mem[base + 1], m_mem[base]};
      if (bus.load_start) begin
        m_loading = 1; m_done = 0; m_err = 0;
        m_count = 0; m_len = 0; m_idle = 0;
      end else if (m_loading) begin
        if (bus.rx_valid) begin
          m_mem[m_count] = bus.rx_byte;
          m_count++;
          m_idle = 0;
          if (m_count % 2 == 0) begin
            m_len = m_count;
            if (m_mem[m_count - 2][4:0] == 5'h14) begin
              m_loading = 0; m_done = 1;
            end else if (m_count == DEPTH) begin
              m_loading = 0; m_err = 1;
            end
          end
        end else if (m_count % 2 == 1) begin
          m_idle++;
          if (m_idle == int'(TO)) begin
            m_loading = 0; m_err = 1;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_script", bus.script, m_script);
      checkOutput("model_ready", {15'b0, bus.ready}, {15'b0, m_done});
      checkOutput("model_error", {15'b0, bus.error}, {15'b0, m_err});
      checkOutput("model_len", {13'b0, bus.len}, {13'b0, 3'(m_len % DEPTH)});
    end
  end

  // One clock: inputs set at a falling edge, consumed by the next rising edge
  task automatic applyStimulus(input logic r, input logic ls, input logic rv,
                               input logic [7:0] b, input logic [AW-1:0] p);
    rst            = r;
    bus.load_start = ls;
    bus.rx_valid   = rv;
    bus.rx_byte    = b;
    bus.pc         = p;
    @(negedge clk);
  endtask

  task automatic checkStatus(input string tag, input logic rdy, input logic err, input logic [AW-1:0] l);
    checkOutput({tag, "_ready"}, {15'b0, bus.ready}, {15'b0, rdy});
    checkOutput({tag, "_error"}, {15'b0, bus.error}, {15'b0, err});
    checkOutput({tag, "_len"}, {13'b0, bus.len}, {13'b0, l});
  endtask

  initial begin
    logic [7:0] b;
    bit r, ls, rv;
    rst = 1'b1;
    bus.load_start = 1'b0; bus.rx_valid = 1'b0; bus.rx_byte = 8'h00; bus.pc = '0;
    @(negedge clk);
    check_en = 1'b1;
    applyStimulus(1, 0, 0, 8'h00, 0);
    checkOutput("reset_script", bus.script, 16'h0000);
    checkStatus("reset", 0, 0, 0);

    // Basic load and reads, including past-end and odd pc
    applyStimulus(0, 1, 0, 8'h00, 0);
    checkOutput("loading_script", bus.script, 16'h0000);
    applyStimulus(0, 0, 1, 8'h0B, 0);
    applyStimulus(0, 0, 1, 8'h15, 0);
    applyStimulus(0, 0, 1, 8'h14, 0);
    applyStimulus(0, 0, 1, 8'h00, 0);
    checkStatus("load4", 1, 0, 4);
    applyStimulus(0, 0, 0, 8'h00, 0);
    checkOutput("pc0", bus.script, 16'h150B);
    applyStimulus(0, 0, 0, 8'h00, 2);
    checkOutput("pc2", bus.script, 16'h0014);
    applyStimulus(0, 0, 0, 8'h00, 6);
    checkOutput("pc6_past_end", bus.script, 16'h0014);
    applyStimulus(0, 0, 0, 8'h00, 1);
    checkOutput("pc1_lsb_ignored", bus.script, 16'h150B);

    // Timeout between lo and hi byte
    applyStimulus(0, 1, 0, 8'h00, 0);
    applyStimulus(0, 0, 1, 8'h01, 0);
    repeat (15) applyStimulus(0, 0, 0, 8'h00, 0);
    checkStatus("timeout_minus1", 0, 0, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);
    checkStatus("timeout", 0, 1, 0);
    applyStimulus(0, 1, 0, 8'h00, 0);
    checkStatus("timeout_clear", 0, 0, 0);

    // Store full without END: 8 bytes count wraps the 3-bit len to 0
    for (int i = 1; i <= 8; i++) applyStimulus(0, 0, 1, 8'(i), 0);
    checkStatus("overflow", 0, 1, 0);
    applyStimulus(0, 0, 1, 8'hFF, 0);
    checkStatus("overflow_9th", 0, 1, 0);

    // load_start wins over a same-cycle byte; reload from DONE
    applyStimulus(0, 1, 1, 8'h14, 0);
    checkStatus("ls_drop", 0, 0, 0);
    applyStimulus(0, 0, 1, 8'h33, 0);
    applyStimulus(0, 0, 1, 8'h44, 0);
    applyStimulus(0, 0, 1, 8'h14, 0);
    applyStimulus(0, 0, 1, 8'h00, 0);
    checkStatus("ls_drop_done", 1, 0, 4);
    applyStimulus(0, 0, 0, 8'h00, 0);
    checkOutput("ls_drop_pc0", bus.script, 16'h4433);
    applyStimulus(0, 1, 0, 8'h00, 0);
    checkStatus("reload_start", 0, 0, 0);
    applyStimulus(0, 0, 1, 8'h14, 0);
    applyStimulus(0, 0, 1, 8'h7E, 0);
    checkStatus("reload_done", 1, 0, 2);
    applyStimulus(0, 0, 0, 8'h00, 0);
    checkOutput("reload_pc0", bus.script, 16'h7E14);
    applyStimulus(0, 0, 0, 8'h00, 2);
    checkOutput("reload_pc2", bus.script, 16'h0014);

    // Reset in the middle of LOAD_HI, then a clean load
    applyStimulus(0, 1, 0, 8'h00, 0);
    applyStimulus(0, 0, 1, 8'h21, 0);
    applyStimulus(0, 0, 1, 8'h22, 0);
    applyStimulus(0, 0, 1, 8'h01, 0);
    checkStatus("pre_rst", 0, 0, 2);
    applyStimulus(1, 0, 0, 8'h00, 0);
    checkOutput("mid_rst_script", bus.script, 16'h0000);
    checkStatus("mid_rst", 0, 0, 0);
    applyStimulus(0, 1, 0, 8'h00, 0);
    applyStimulus(0, 0, 1, 8'h05, 0);
    applyStimulus(0, 0, 1, 8'hAA, 0);
    applyStimulus(0, 0, 1, 8'h14, 0);
    applyStimulus(0, 0, 1, 8'h00, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);
    checkOutput("post_rst_pc0", bus.script, 16'hAA05);
    applyStimulus(0, 0, 0, 8'h00, 2);
    checkOutput("post_rst_pc2", bus.script, 16'h0014);

    // Random traffic with periodic quiet windows that provoke timeouts
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      ls = ($urandom_range(0, 39) == 0);
      if ((i % 500) < 60) rv = ($urandom_range(0, 32) == 0);
      else                rv = ($urandom_range(0, 1) == 1);
      b = 8'($urandom);
      if ($urandom_range(0, 4) == 0) b[4:0] = 5'h14;
      applyStimulus(r, ls, rv, b, AW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
